// File: rtl/cgra_run_ctrl.sv
// Run controller for the 3x3 torus PE array.
// Accepts a start with a compute-cycle count and holds the array busy for that many cycles.
// Host load words are staged onto the two load lanes while the array runs.
// After the run it drains the array pipeline, captures both store lanes,
// and pulses Done once the drain is complete.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for Start; all array-facing outputs low
// RUN   | PE_Array_Busy high, Cycle_Cnt counts 0..N-1
// DRAIN | array stopped, store lanes still captured for DRAIN_CYCLES
// DONE  | one-cycle Done pulse, then back to IDLE
module cgra_run_ctrl #(
    parameter int DWIDTH       = 32,
    parameter int CWIDTH       = 16,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Abort,
    input  logic [CWIDTH-1:0] Compute_Cycles,
    input  logic [DWIDTH-1:0] Load0_In,
    input  logic [DWIDTH-1:0] Load1_In,
    output logic [DWIDTH-1:0] Data0_Load,
    output logic [DWIDTH-1:0] Data1_Load,
    input  logic [DWIDTH-1:0] Data0_Store,
    input  logic [DWIDTH-1:0] Data1_Store,
    output logic              PE_Array_Busy,
    output logic [DWIDTH-1:0] Store0_Out,
    output logic [DWIDTH-1:0] Store1_Out,
    output logic              Store_Valid,
    output logic [CWIDTH-1:0] Cycle_Cnt,
    output logic              Done,
    output logic              Ctrl_Busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Drain timer is a down-counter loaded with DRAIN_CYCLES-1; terminal count is zero.
    localparam int DRW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int DRAIN_LOAD_I = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
    localparam logic [DRW-1:0] DRAIN_LOAD = DRW'(DRAIN_LOAD_I);

    state_t            state;
    state_t            state_nx;
    logic [CWIDTH-1:0] n_q;
    logic [DRW-1:0]    drain_cnt;
    logic              last_run;

    assign last_run = (Cycle_Cnt == (n_q - CWIDTH'(1)));

    // Next-state decision; Abort beats everything except Reset.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (Start && !Abort) begin
                    state_nx = (Compute_Cycles != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (Abort) begin
                    state_nx = IDLE;
                end else if (last_run) begin
                    state_nx = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (Abort) begin
                    state_nx = IDLE;
                end else if (drain_cnt == '0) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register, control outputs registered from the next state, run and drain counters.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= IDLE;
            PE_Array_Busy <= 1'b0;
            Done          <= 1'b0;
            Ctrl_Busy     <= 1'b0;
            n_q           <= '0;
            Cycle_Cnt     <= '0;
            drain_cnt     <= '0;
        end else begin
            state         <= state_nx;
            PE_Array_Busy <= (state_nx == RUN);
            Done          <= (state_nx == DONE);
            Ctrl_Busy     <= (state_nx != IDLE);
            if (state == IDLE && state_nx != IDLE) begin
                n_q       <= Compute_Cycles;
                Cycle_Cnt <= '0;
            end else if (state == RUN) begin
                Cycle_Cnt <= Cycle_Cnt + CWIDTH'(1);
            end
            if (state_nx == DRAIN && state != DRAIN) begin
                drain_cnt <= DRAIN_LOAD;
            end else if (state == DRAIN) begin
                drain_cnt <= drain_cnt - DRW'(1);
            end
        end
    end

    // Load lanes follow the host words while the array runs, zero otherwise.
    always_ff @(posedge Clk) begin
        if (Reset || state_nx != RUN) begin
            Data0_Load <= '0;
            Data1_Load <= '0;
        end else begin
            Data0_Load <= Load0_In;
            Data1_Load <= Load1_In;
        end
    end

    // Store lanes are captured one cycle behind every RUN/DRAIN cycle; data holds otherwise.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Store_Valid <= 1'b0;
            Store0_Out  <= '0;
            Store1_Out  <= '0;
        end else if ((state == RUN || state == DRAIN) && !Abort) begin
            Store_Valid <= 1'b1;
            Store0_Out  <= Data0_Store;
            Store1_Out  <= Data1_Store;
        end else begin
            Store_Valid <= 1'b0;
        end
    end

endmodule

// File: doc/cgra_run_ctrl.md
Name: cgra_run_ctrl

Overview:
Run controller and I/O staging stage that sits directly upstream and downstream of the 3x3 torus PE array.
- Accepts a host Start plus a compute-cycle count.
- Drives the array's PE_Array_Busy for exactly that many cycles, staging host load words onto the two load lanes.
- Afterwards drains the array pipeline, capturing the two store lanes, and reports completion with a Done pulse.

Parameters:
DWIDTH, 32, width of load/store lanes
CWIDTH, 16, width of compute-cycle count and cycle counter
DRAIN_CYCLES, 4, cycles store capture continues after PE_Array_Busy falls (0 legal)

Ports:
Clk  input  1  clock, all logic rising-edge
Reset  input  1  synchronous, active-high reset
Start  input  1  host start request, sampled only in IDLE
Abort  input  1  host abort, highest priority after Reset
Compute_Cycles  input  CWIDTH  number of busy cycles, latched on accepted Start
Load0_In  input  DWIDTH  host word for load lane 0
Load1_In  input  DWIDTH  host word for load lane 1
Data0_Load  output  DWIDTH  registered load lane 0 to array
Data1_Load  output  DWIDTH  registered load lane 1 to array
Data0_Store  input  DWIDTH  store lane 0 from array
Data1_Store  input  DWIDTH  store lane 1 from array
PE_Array_Busy  output  1  array run enable
Store0_Out  output  DWIDTH  captured store lane 0
Store1_Out  output  DWIDTH  captured store lane 1
Store_Valid  output  1  Store0_Out/Store1_Out valid this cycle
Cycle_Cnt  output  CWIDTH  busy cycles elapsed in current run
Done  output  1  one-cycle completion pulse
Ctrl_Busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE; all outputs 0; latched count 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: Start=1 with Compute_Cycles=N.
  - N!=0: latch N, go to RUN.
  - N=0: go to DONE directly; PE_Array_Busy never rises.
- RUN: PE_Array_Busy=1 (registered output, equals state==RUN).
  - Cycle_Cnt=0 in the first RUN cycle and increments each RUN cycle.
  - When Cycle_Cnt==N-1, next state is DRAIN, or DONE if DRAIN_CYCLES=0.
  - Net effect: Start accepted at edge t gives busy high for exactly N cycles starting t+1.
- DRAIN: PE_Array_Busy=0; internal drain counter runs DRAIN_CYCLES cycles, then DONE.
- DONE: Done=1 for exactly one cycle, then IDLE. Cycle_Cnt holds final value N until the next accepted Start, then clears to 0.
- Load staging: in RUN, Data0_Load/Data1_Load are registered from Load0_In/Load1_In every cycle (1-cycle latency). Outside RUN they are driven to 0.
- Store capture: Store_Valid, Store0_Out and Store1_Out are registered one cycle after any RUN or DRAIN cycle, sampling Data0_Store/Data1_Store.
  - Store_Valid is high for N+DRAIN_CYCLES consecutive cycles, starting t+2.
  - Store0_Out/Store1_Out hold their last value when Store_Valid=0.
- Start while not IDLE: ignored. Compute_Cycles changes after acceptance have no effect.
- Abort in RUN, DRAIN or DONE: next state IDLE. PE_Array_Busy, Store_Valid and Done are 0 from the next cycle; no Done pulse. Abort in IDLE has no effect and overrides a simultaneous Start.
- Reset mid-run: identical to reset from any state; all outputs 0 the next cycle.
- Ctrl_Busy=1 in RUN, DRAIN and DONE.
- N=2^CWIDTH-1 is legal; Cycle_Cnt never wraps within a run.

Test Plan:
- Basic run: Reset, then Start with N=5, DRAIN_CYCLES=4, Start at edge 10 -> PE_Array_Busy high cycles 11-15; Store_Valid high 12-20; Done high at 20 only; Cycle_Cnt=5 afterwards.
- Data path: Load0_In=cycle index, Data0_Store=0xA5A50000+cycle index, N=3 -> Data0_Load equals previous-cycle Load0_In during RUN and 0 otherwise; Store0_Out sequence equals Data0_Store delayed 1 cycle; Store0_Out holds last value after Store_Valid falls.
- Zero and edge counts: N=0 -> Done one cycle after Start, PE_Array_Busy never high, Store_Valid never high. N=1 with DRAIN_CYCLES=0 -> busy 1 cycle, Done the cycle after busy falls.
- Abort: Abort at 3rd RUN cycle of N=10 -> busy low next cycle, no Done, Ctrl_Busy=0. Abort together with Start in IDLE -> no run.
- Ignored Start: Start pulses during RUN and DRAIN with a different Compute_Cycles -> busy length unchanged, single Done.
- Reset mid-operation: Reset asserted during DRAIN -> all outputs 0 next cycle; a fresh Start with N=2 then runs normally.
